// File: rtl/io_switch_debounce.sv
// io_switch_debounce: 2-FF synchroniser plus per-bit counter debounce for two switch ports.
// Optional feature macro IO_DEBOUNCE_EVENT_EN adds sticky per-bit flip flags (evt_flags/evt_clear).
module io_sw_db_bit #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic io_clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic flip
);
    typedef enum logic {IDLE, COUNT} state_t;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1, s2;

    // flip marks the edge on which stable takes the new value; the top registers it into changed
    always_comb begin
        flip = 1'b0;
        if (s2 != stable) begin
            if (state == IDLE) flip = (DEBOUNCE_CYCLES == 1);
            else               flip = (cnt == TERM);
        end
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (flip) begin
                stable <= s2;
                cnt    <= '0;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (s2 != stable) begin
                            state <= COUNT;
                            cnt   <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    COUNT: begin
                        if (s2 == stable) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

module io_switch_debounce #(
    parameter int WIDTH           = 5,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             io_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw0_raw,
    input  logic [WIDTH-1:0] sw1_raw,
    output logic [31:0]      in_port0,
    output logic [31:0]      in_port1,
    output logic             changed
`ifdef IO_DEBOUNCE_EVENT_EN
    ,
    input  logic             evt_clear,
    output logic [2*WIDTH-1:0] evt_flags
`endif
);
    logic [2*WIDTH-1:0] raw_all, stable_all, flip_all;

    assign raw_all = {sw1_raw, sw0_raw};

    for (genvar i = 0; i < 2*WIDTH; i++) begin : g_bit
        io_sw_db_bit #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .io_clk(io_clk),
            .reset (reset),
            .raw   (raw_all[i]),
            .stable(stable_all[i]),
            .flip  (flip_all[i])
        );
    end

    assign in_port0 = {{(32-WIDTH){1'b0}}, stable_all[WIDTH-1:0]};
    assign in_port1 = {{(32-WIDTH){1'b0}}, stable_all[2*WIDTH-1:WIDTH]};

    always_ff @(posedge io_clk) begin
        if (reset) changed <= 1'b0;
        else       changed <= |flip_all;
    end

`ifdef IO_DEBOUNCE_EVENT_EN
    // a flip landing on the clearing edge survives the clear
    always_ff @(posedge io_clk) begin
        if (reset)          evt_flags <= '0;
        else if (evt_clear) evt_flags <= flip_all;
        else                evt_flags <= evt_flags | flip_all;
    end
`endif
endmodule

// File: tb/tb_io_switch_debounce.sv
// Self-checking bench for io_switch_debounce (DEBOUNCE_CYCLES=4): cycle scoreboard against a
// run-length model, a vector table, and hand-checked latency/glitch/reset sequences.
module tb_io_switch_debounce;
    localparam int W = 5;
    localparam int D = 4;

    logic           io_clk = 1'b0;
    logic           reset  = 1'b1;
    logic [W-1:0]   sw0_raw = '0;
    logic [W-1:0]   sw1_raw = '0;
    logic [31:0]    in_port0, in_port1;
    logic           changed;
`ifdef IO_DEBOUNCE_EVENT_EN
    logic           evt_clear = 1'b0;
    logic [2*W-1:0] evt_flags;
`endif

    always #5 io_clk = ~io_clk;

    io_switch_debounce #(.WIDTH(W), .CNT_W(16), .DEBOUNCE_CYCLES(D)) dut (
        .io_clk  (io_clk),
        .reset   (reset),
        .sw0_raw (sw0_raw),
        .sw1_raw (sw1_raw),
        .in_port0(in_port0),
        .in_port1(in_port1),
        .changed (changed)
`ifdef IO_DEBOUNCE_EVENT_EN
        ,
        .evt_clear(evt_clear),
        .evt_flags(evt_flags)
`endif
    );

    typedef struct packed {
        logic [31:0]    p0;
        logic [31:0]    p1;
        logic           chg;
        logic [2*W-1:0] evt;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [W-1:0] s0;
        logic [W-1:0] s1;
        int         cyc;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    exp_t           q[$];
    int             tests = 0;
    int             fails = 0;
    logic [2*W-1:0] m_s1 = '0, m_s2 = '0, m_stb = '0, m_evt = '0;
    int             m_run[2*W];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: a bit flips once s2 has disagreed with stable for D consecutive edges.
    task automatic model_edge();
        logic [2*W-1:0] nstb;
        logic [2*W-1:0] fl;
        exp_t e;
        nstb = m_stb;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stb = '0; m_evt = '0;
            for (int i = 0; i < 2*W; i++) m_run[i] = 0;
            fl = '0;
        end else begin
            for (int i = 0; i < 2*W; i++) begin
                if (m_s2[i] != m_stb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        nstb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            fl = nstb ^ m_stb;
            m_stb = nstb;
            m_s2 = m_s1;
            m_s1 = {sw1_raw, sw0_raw};
`ifdef IO_DEBOUNCE_EVENT_EN
            m_evt = evt_clear ? fl : (m_evt | fl);
`endif
        end
        e.p0  = {27'b0, m_stb[W-1:0]};
        e.p1  = {27'b0, m_stb[2*W-1:W]};
        e.chg = (fl != '0);
        e.evt = m_evt;
        q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_edge();
        @(posedge io_clk);
        #1;
        if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_empty: got no entry expected one");
        end else begin
            e = q.pop_front();
            check("sb_p0", {32'b0, in_port0}, {32'b0, e.p0});
            check("sb_p1", {32'b0, in_port1}, {32'b0, e.p1});
            check("sb_chg", {63'b0, changed}, {63'b0, e.chg});
`ifdef IO_DEBOUNCE_EVENT_EN
            check("sb_evt", {54'b0, evt_flags}, {54'b0, e.evt});
`endif
        end
    endtask

    vec_t tbl[8];
    int   pulses;

    initial begin
        for (int i = 0; i < 2*W; i++) m_run[i] = 0;
        tbl[0] = '{1'b0, 5'h0A, 5'h03, 8, 32'h0A, 32'h03};
        tbl[1] = '{1'b0, 5'h0B, 5'h03, 2, 32'h0A, 32'h03};
        tbl[2] = '{1'b0, 5'h0A, 5'h03, 8, 32'h0A, 32'h03};
        tbl[3] = '{1'b0, 5'h1F, 5'h1C, 6, 32'h1F, 32'h1C};
        tbl[4] = '{1'b0, 5'h00, 5'h1C, 3, 32'h1F, 32'h1C};
        tbl[5] = '{1'b0, 5'h1F, 5'h1C, 8, 32'h1F, 32'h1C};
        tbl[6] = '{1'b1, 5'h1F, 5'h1F, 2, 32'h00, 32'h00};
        tbl[7] = '{1'b0, 5'h1F, 5'h1F, 6, 32'h1F, 32'h1F};

        // reset held with switches high
        reset = 1'b1; sw0_raw = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_p0", {32'b0, in_port0}, 64'h0);
            check("rst_p1", {32'b0, in_port1}, 64'h0);
            check("rst_chg", {63'b0, changed}, 64'h0);
        end
        reset = 1'b0; sw0_raw = '0;
        for (int i = 0; i < 6; i++) cycle();

        // latency: update lands at edge k+5
        sw0_raw = 5'h15;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 4) check("lat_pre_p0", {32'b0, in_port0}, 64'h0);
            if (i == 5) begin
                check("lat_p0", {32'b0, in_port0}, 64'h15);
                check("lat_chg", {63'b0, changed}, 64'h1);
            end
            if (i == 6) check("lat_chg_drop", {63'b0, changed}, 64'h0);
        end

        // 3-cycle glitch rejected
        pulses = 0;
        sw1_raw = 5'h01;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) sw1_raw = '0;
            cycle();
            if (changed) pulses++;
            if (in_port1 != 32'h0) pulses++;
        end
        check("glitch_quiet", 64'(pulses), 64'h0);

        // simultaneous flips on both ports
        reset = 1'b1; sw0_raw = '0; sw1_raw = '0;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        sw0_raw = 5'h01; sw1_raw = 5'h10;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (changed) pulses++;
            if (i == 5) begin
                check("simul_p0", {32'b0, in_port0}, 64'h01);
                check("simul_p1", {32'b0, in_port1}, 64'h10);
            end
        end
        check("simul_pulses", 64'(pulses), 64'h1);

        // reset mid-debounce discards progress
        sw0_raw = 5'h08; sw1_raw = '0;
        cycle(); cycle();
        reset = 1'b1;
        cycle(); cycle();
        check("mid_rst_p0", {32'b0, in_port0}, 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (i == 4) check("post_rst_pre", {32'b0, in_port0}, 64'h0);
            if (i == 5) check("post_rst_p0", {32'b0, in_port0}, 64'h08);
        end

`ifdef IO_DEBOUNCE_EVENT_EN
        // flip on the clearing edge keeps its flag
        sw1_raw = 5'h04;
        for (int i = 0; i < 8; i++) begin
            evt_clear = (i == 5);
            cycle();
            if (i >= 5) check("evt_set", {54'b0, evt_flags}, 64'h080);
        end
        evt_clear = 1'b1;
        cycle();
        check("evt_clr", {54'b0, evt_flags}, 64'h0);
        evt_clear = 1'b0;
`endif

        // vector table
        for (int v = 0; v < 8; v++) begin
            reset = tbl[v].rst; sw0_raw = tbl[v].s0; sw1_raw = tbl[v].s1;
            for (int c = 0; c < tbl[v].cyc; c++) cycle();
            check($sformatf("vec%0d_p0", v), {32'b0, in_port0}, {32'b0, tbl[v].e0});
            check($sformatf("vec%0d_p1", v), {32'b0, in_port1}, {32'b0, tbl[v].e1});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
